// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types.
// Holds the default 1024x768@60 (65 MHz pixel clock) timing, the derived
// totals and active-window start positions, and the 11-bit counter type
// used by the sync generator.
package vga_timing_pkg;

  localparam int ADDR_W  = 11;
  localparam int MAX_TOT = (1 << ADDR_W) - 1;

  localparam int DEF_H_SYNC = 136;
  localparam int DEF_H_BP   = 160;
  localparam int DEF_H_ACT  = 1024;
  localparam int DEF_H_FP   = 24;
  localparam int DEF_V_SYNC = 6;
  localparam int DEF_V_BP   = 29;
  localparam int DEF_V_ACT  = 768;
  localparam int DEF_V_FP   = 3;

  localparam int DEF_H_TOT       = DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;
  localparam int DEF_V_TOT       = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;
  localparam int DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BP;

  typedef logic [ADDR_W-1:0] cnt_t;

endpackage

// File: rtl/sync_delay_line.sv
// Parameterised-depth single-bit shift register used to align strobes with
// the frame-buffer read latency.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset; every tap resets to RST_VAL
//   din   - input bit
//   dout  - din delayed DEPTH clocks (DEPTH = 0 is a straight wire)
module sync_delay_line #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_taps
    logic [DEPTH-1:0] taps;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        taps <= {DEPTH{RST_VAL}};
      end else begin
        taps[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          taps[i] <= taps[i-1];
        end
      end
    end

    assign dout = taps[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_module.sv
// VGA timing generator. Free-running horizontal/vertical counters feed a
// registered stage-0 decode (fetch request, column/row address, frame start)
// for the frame-buffer read port; ready and the sync strobes are delayed by
// DATA_LAT clocks so they line up with the returned pixel word.
// Ports:
//   CLK             - pixel clock
//   RSTn            - asynchronous active-low reset
//   Req_Sig         - pixel fetch request (stage 0)
//   Column_Addr_Sig - active column, 0 outside the active region (stage 0)
//   Row_Addr_Sig    - active row, 0 outside the active region (stage 0)
//   Frame_Start_Sig - one-clock pulse when decoding count (0,0) (stage 0)
//   Ready_Sig       - Req_Sig delayed DATA_LAT clocks
//   HSYNC_Sig       - horizontal sync delayed DATA_LAT clocks
//   VSYNC_Sig       - vertical sync delayed DATA_LAT clocks
module vga_sync_module
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACT    = DEF_H_ACT,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACT    = DEF_V_ACT,
  parameter int V_FP     = DEF_V_FP,
  parameter int SYNC_POL = 0,
  parameter int DATA_LAT = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  output logic              Req_Sig,
  output logic [ADDR_W-1:0] Column_Addr_Sig,
  output logic [ADDR_W-1:0] Row_Addr_Sig,
  output logic              Frame_Start_Sig,
  output logic              Ready_Sig,
  output logic              HSYNC_Sig,
  output logic              VSYNC_Sig
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  if (H_TOT > MAX_TOT || V_TOT > MAX_TOT) begin : g_tot_check
    $error("vga_sync_module: H_TOT/V_TOT exceed 11-bit counter range");
  end
  if (DATA_LAT < 0 || DATA_LAT > 7) begin : g_lat_check
    $error("vga_sync_module: DATA_LAT must be 0..7");
  end

  localparam cnt_t H_LAST  = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOT - 1);
  localparam cnt_t H_SEND  = cnt_t'(H_SYNC);
  localparam cnt_t V_SEND  = cnt_t'(V_SYNC);
  localparam cnt_t H_ASTRT = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t V_ASTRT = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t H_AEND  = cnt_t'(H_SYNC + H_BP + H_ACT);
  localparam cnt_t V_AEND  = cnt_t'(V_SYNC + V_BP + V_ACT);

  localparam logic SYNC_ON   = (SYNC_POL != 0);
  localparam logic SYNC_IDLE = ~SYNC_ON;

  cnt_t h_cnt, v_cnt;
  logic h_act, v_act, act;
  logic hs_s0, vs_s0;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign h_act = (h_cnt >= H_ASTRT) && (h_cnt < H_AEND);
  assign v_act = (v_cnt >= V_ASTRT) && (v_cnt < V_AEND);
  assign act   = h_act && v_act;

  // Stage 0: decode of the counter value held before this edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Req_Sig         <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
      Frame_Start_Sig <= 1'b0;
      hs_s0           <= SYNC_IDLE;
      vs_s0           <= SYNC_IDLE;
    end else begin
      Req_Sig         <= act;
      Column_Addr_Sig <= act ? (h_cnt - H_ASTRT) : '0;
      Row_Addr_Sig    <= act ? (v_cnt - V_ASTRT) : '0;
      Frame_Start_Sig <= (h_cnt == '0) && (v_cnt == '0);
      hs_s0           <= (h_cnt < H_SEND) ? SYNC_ON : SYNC_IDLE;
      // v_cnt only moves when h_cnt wraps, so VSYNC changes on the h=0 decode.
      vs_s0           <= (v_cnt < V_SEND) ? SYNC_ON : SYNC_IDLE;
    end
  end

  sync_delay_line #(.DEPTH(DATA_LAT), .RST_VAL(1'b0)) u_ready_dly (
    .clk   (CLK),
    .rst_n (RSTn),
    .din   (Req_Sig),
    .dout  (Ready_Sig)
  );

  sync_delay_line #(.DEPTH(DATA_LAT), .RST_VAL(SYNC_IDLE)) u_hsync_dly (
    .clk   (CLK),
    .rst_n (RSTn),
    .din   (hs_s0),
    .dout  (HSYNC_Sig)
  );

  sync_delay_line #(.DEPTH(DATA_LAT), .RST_VAL(SYNC_IDLE)) u_vsync_dly (
    .clk   (CLK),
    .rst_n (RSTn),
    .din   (vs_s0),
    .dout  (VSYNC_Sig)
  );

endmodule

// File: tb/tb_vga_sync_module.sv
// Scoreboard bench for vga_sync_module using a reduced timing geometry so
// several whole frames fit in a short run. Two instances share clock and
// reset: A (DATA_LAT=2, negative sync) and B (DATA_LAT=0, positive sync).
// Expected outputs come from an arithmetic model of the frame position.
module tb_vga_sync_module;

  localparam int HS = 4, HB = 5, HA = 16, HF = 3;
  localparam int VS = 2, VB = 3, VA = 6, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        req_a, fs_a, rdy_a, hs_a, vs_a;
  logic [10:0] col_a, row_a;
  logic        req_b, fs_b, rdy_b, hs_b, vs_b;
  logic [10:0] col_b, row_b;

  always #5 clk = ~clk;

  vga_sync_module #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .SYNC_POL(0), .DATA_LAT(2)
  ) dut_a (
    .CLK(clk), .RSTn(rst_n), .Req_Sig(req_a), .Column_Addr_Sig(col_a),
    .Row_Addr_Sig(row_a), .Frame_Start_Sig(fs_a), .Ready_Sig(rdy_a),
    .HSYNC_Sig(hs_a), .VSYNC_Sig(vs_a)
  );

  vga_sync_module #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .SYNC_POL(1), .DATA_LAT(0)
  ) dut_b (
    .CLK(clk), .RSTn(rst_n), .Req_Sig(req_b), .Column_Addr_Sig(col_b),
    .Row_Addr_Sig(row_b), .Frame_Start_Sig(fs_b), .Ready_Sig(rdy_b),
    .HSYNC_Sig(hs_b), .VSYNC_Sig(vs_b)
  );

  typedef struct {
    logic req;
    int   col;
    int   row;
    logic fs;
    logic hs;  // sync asserted (polarity applied at compare time)
    logic vs;
  } st_t;

  typedef struct {
    st_t s0;
    st_t d2;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int k = 0;  // edges since reset release; 0 while in reset

  // Stage-0 outputs on edge k decode frame position k-1.
  function automatic st_t model(int kk);
    st_t s;
    int p, h, v;
    logic ha, va;
    s = '{req: 1'b0, col: 0, row: 0, fs: 1'b0, hs: 1'b0, vs: 1'b0};
    if (kk < 1) return s;
    p = (kk - 1) % FT;
    h = p % HT;
    v = p / HT;
    ha = (h >= HS + HB) && (h < HS + HB + HA);
    va = (v >= VS + VB) && (v < VS + VB + VA);
    s.req = ha && va;
    if (s.req) begin
      s.col = h - (HS + HB);
      s.row = v - (VS + VB);
    end
    s.fs = (p == 0);
    s.hs = (h < HS);
    s.vs = (v < VS);
    return s;
  endfunction

  function automatic logic lvl(logic asserted, logic pol);
    return asserted ? pol : ~pol;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-buffer model: returns {row,col} of the request seen two clocks ago.
  logic [21:0] mem_p1 = '0, mem_p2 = '0, mem_out;

  always @(negedge clk) begin
    exp_t e;
    mem_out = mem_p2;
    mem_p2  = mem_p1;
    mem_p1  = {row_a, col_a};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("a_req", 32'(req_a), 32'(e.s0.req));
      chk("a_col", 32'(col_a), 32'(e.s0.col));
      chk("a_row", 32'(row_a), 32'(e.s0.row));
      chk("a_fs", 32'(fs_a), 32'(e.s0.fs));
      chk("a_ready", 32'(rdy_a), 32'(e.d2.req));
      chk("a_hsync", 32'(hs_a), 32'(lvl(e.d2.hs, 1'b0)));
      chk("a_vsync", 32'(vs_a), 32'(lvl(e.d2.vs, 1'b0)));
      if (e.d2.req) begin
        chk("a_mem_align", 32'(mem_out), 32'({11'(e.d2.row), 11'(e.d2.col)}));
      end
      chk("b_req", 32'(req_b), 32'(e.s0.req));
      chk("b_col", 32'(col_b), 32'(e.s0.col));
      chk("b_row", 32'(row_b), 32'(e.s0.row));
      chk("b_fs", 32'(fs_b), 32'(e.s0.fs));
      chk("b_ready", 32'(rdy_b), 32'(e.s0.req));
      chk("b_hsync", 32'(hs_b), 32'(lvl(e.s0.hs, 1'b1)));
      chk("b_vsync", 32'(vs_b), 32'(lvl(e.s0.vs, 1'b1)));
    end
  end

  task automatic step();
    @(posedge clk);
    if (rst_n) k++;
    else k = 0;
    #1;
    sb.push_back('{s0: model(k), d2: model(k - 2)});
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Assert reset between edges and check outputs before any clock edge.
  task automatic async_reset(int hold);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_req", 32'(req_a), 0);
    chk("rst_a_col", 32'(col_a), 0);
    chk("rst_a_row", 32'(row_a), 0);
    chk("rst_a_fs", 32'(fs_a), 0);
    chk("rst_a_ready", 32'(rdy_a), 0);
    chk("rst_a_hsync", 32'(hs_a), 1);
    chk("rst_a_vsync", 32'(vs_a), 1);
    chk("rst_b_req", 32'(req_b), 0);
    chk("rst_b_col", 32'(col_b), 0);
    chk("rst_b_row", 32'(row_b), 0);
    chk("rst_b_fs", 32'(fs_b), 0);
    chk("rst_b_ready", 32'(rdy_b), 0);
    chk("rst_b_hsync", 32'(hs_b), 0);
    chk("rst_b_vsync", 32'(vs_b), 0);
    run(hold);
    release_rst();
  endtask

  initial begin
    rst_n = 1'b0;
    run(4);
    release_rst();
    // Three whole frames plus change: frame-start period, sync widths, every pixel.
    run(3 * FT + 40);
    // Reset landing mid-active-pixel on row 2.
    async_reset(2);
    run((VS + VB + 2) * HT + HS + HB + 7);
    async_reset(1);
    // Random reset points and hold lengths.
    for (int r = 0; r < 4; r++) begin
      run($urandom_range(FT + 30, 5));
      async_reset($urandom_range(4, 1));
    end
    run(FT + 30);
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
